// File: rtl/result_arbiter.sv
// Round-robin merge of NUM_WORKERS worker-result streams into one registered token
// stream. Each token carries the index of the worker that produced it.
module result_arbiter #(
  parameter int NUM_WORKERS         = 4,
  parameter int WID_WIDTH           = 2,
  parameter int WORKER_RESULT_WIDTH = 67
) (
  input  logic                                       CLK,
  input  logic                                       RST,
  input  logic [NUM_WORKERS-1:0]                     WR_VALID,
  input  logic [NUM_WORKERS*WORKER_RESULT_WIDTH-1:0] WR_DATA,
  output logic [NUM_WORKERS-1:0]                     WR_READY,
  output logic                                       TK_VALID,
  output logic [WORKER_RESULT_WIDTH-1:0]             TK_DATA,
  output logic [WID_WIDTH-1:0]                       TK_SRC,
  input  logic                                       TK_READY,
  output logic [31:0]                                TK_COUNT
);

  localparam int WRW = WORKER_RESULT_WIDTH;

  logic [WID_WIDTH-1:0] ptr_q, ptr_d;
  logic                 tk_valid_q, tk_valid_d;
  logic [WRW-1:0]       tk_data_q, tk_data_d;
  logic [WID_WIDTH-1:0] tk_src_q, tk_src_d;
  logic [31:0]          tk_count_q, tk_count_d;

  logic                 grant_valid;
  logic [WID_WIDTH-1:0] grant_idx;
  logic [WRW-1:0]       grant_data;
  logic                 can_load;
  logic                 load;
  logic                 drain;

  // Two passes give the wrapping search: indices at/above ptr first, then the rest.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    for (int i = 0; i < NUM_WORKERS; i++) begin
      if (!grant_valid && WR_VALID[i] && (i >= int'(ptr_q))) begin
        grant_valid = 1'b1;
        grant_idx   = WID_WIDTH'(i);
        grant_data  = WR_DATA[i*WRW +: WRW];
      end
    end
    for (int i = 0; i < NUM_WORKERS; i++) begin
      if (!grant_valid && WR_VALID[i]) begin
        grant_valid = 1'b1;
        grant_idx   = WID_WIDTH'(i);
        grant_data  = WR_DATA[i*WRW +: WRW];
      end
    end
  end

  assign can_load = !tk_valid_q || TK_READY;
  assign load     = !RST && can_load && grant_valid;
  assign drain    = tk_valid_q && TK_READY;

  for (genvar gi = 0; gi < NUM_WORKERS; gi++) begin : g_ready
    assign WR_READY[gi] = load && (grant_idx == WID_WIDTH'(gi));
  end

  always_comb begin
    ptr_d      = ptr_q;
    tk_valid_d = tk_valid_q;
    tk_data_d  = tk_data_q;
    tk_src_d   = tk_src_q;
    tk_count_d = tk_count_q;
    if (load) begin
      tk_valid_d = 1'b1;
      tk_data_d  = grant_data;
      tk_src_d   = grant_idx;
      ptr_d      = (grant_idx == WID_WIDTH'(NUM_WORKERS - 1)) ? '0
                                                               : grant_idx + WID_WIDTH'(1);
    end else if (drain) begin
      tk_valid_d = 1'b0;
    end
    if (drain) begin
      tk_count_d = tk_count_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q      <= '0;
      tk_valid_q <= 1'b0;
      tk_data_q  <= '0;
      tk_src_q   <= '0;
      tk_count_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      tk_valid_q <= tk_valid_d;
      tk_data_q  <= tk_data_d;
      tk_src_q   <= tk_src_d;
      tk_count_q <= tk_count_d;
    end
  end

  assign TK_VALID = tk_valid_q;
  assign TK_DATA  = tk_data_q;
  assign TK_SRC   = tk_src_q;
  assign TK_COUNT = tk_count_q;

endmodule

// File: tb/tb_result_arbiter.sv
// Scenario bench for result_arbiter: expected tokens are queued as stimulus is
// applied and popped when the merged stream delivers them.
module tb_result_arbiter;

  localparam int N = 4;
  localparam int W = 67;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   wr_valid;
  logic [N*W-1:0] wr_data;
  logic [N-1:0]   WR_READY;
  logic           TK_VALID;
  logic [W-1:0]   TK_DATA;
  logic [1:0]     TK_SRC;
  logic           tk_ready;
  logic [31:0]    TK_COUNT;

  typedef struct {
    logic [1:0]   src;
    logic [W-1:0] data;
  } tok_t;

  tok_t exp_q[$];
  tok_t e;
  int   total = 0;
  int   bad = 0;
  int   exp_count = 0;

  result_arbiter #(.NUM_WORKERS(N), .WID_WIDTH(2), .WORKER_RESULT_WIDTH(W)) dut (
    .CLK(clk), .RST(rst), .WR_VALID(wr_valid), .WR_DATA(wr_data), .WR_READY(WR_READY),
    .TK_VALID(TK_VALID), .TK_DATA(TK_DATA), .TK_SRC(TK_SRC), .TK_READY(tk_ready),
    .TK_COUNT(TK_COUNT)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input int w, input int n);
    return {3'(w + 1), 16'(16'h0100 * w + n), 16'(16'hc0c0 ^ n), 32'(32'h1000_0000 * w + n * 7 + 1)};
  endfunction

  task automatic set_wr(input int i, input logic [W-1:0] v);
    wr_data[i*W +: W] = v;
  endtask

  task automatic push(input int s, input logic [W-1:0] d);
    tok_t t;
    t.src  = 2'(s);
    t.data = d;
    exp_q.push_back(t);
  endtask

  task automatic test_reset();
    rst = 1'b1; tk_ready = 1'b1; wr_valid = 4'b1111; wr_data = '0;
    for (int i = 0; i < N; i++) set_wr(i, mk(i, 99));
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (WR_READY !== 4'b0000 || TK_VALID !== 1'b0 || TK_COUNT !== 32'd0 || TK_SRC !== 2'd0 || TK_DATA !== '0) begin
      bad++;
      $display("FAIL reset_state: got rdy=%b vld=%b cnt=%0d src=%0d, required rdy=0000 vld=0 cnt=0 src=0",
               WR_READY, TK_VALID, TK_COUNT, TK_SRC);
    end
    @(posedge clk); #1 rst = 1'b0;
    push(0, mk(0, 99));
    @(negedge clk);
    total++;
    if (WR_READY !== 4'b0001) begin
      bad++;
      $display("FAIL reset_first_grant: got rdy=%b, required 0001", WR_READY);
    end
    @(posedge clk); #1 wr_valid = '0;
    @(negedge clk);
    e = exp_q.pop_front(); exp_count++;
    total++;
    if (TK_VALID !== 1'b1 || TK_SRC !== e.src || TK_DATA !== e.data) begin
      bad++;
      $display("FAIL reset_token: got vld=%b src=%0d data=%h, required vld=1 src=%0d data=%h",
               TK_VALID, TK_SRC, TK_DATA, e.src, e.data);
    end else $display("token src=%0d data=%h", TK_SRC, TK_DATA);
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [W-1:0] d;
    d = {3'b110, 16'h00ff, 16'heeee, 32'hdead_beef};
    set_wr(2, d); wr_valid = 4'b0100; push(2, d);
    @(negedge clk);
    total++;
    if (WR_READY !== 4'b0100 || TK_VALID !== 1'b0) begin
      bad++;
      $display("FAIL single_grant: got rdy=%b vld=%b, required rdy=0100 vld=0", WR_READY, TK_VALID);
    end
    @(posedge clk); #1 wr_valid = '0;
    @(negedge clk);
    e = exp_q.pop_front(); exp_count++;
    total++;
    if (TK_VALID !== 1'b1 || TK_SRC !== e.src || TK_DATA !== e.data) begin
      bad++;
      $display("FAIL single_token: got vld=%b src=%0d data=%h, required vld=1 src=%0d data=%h",
               TK_VALID, TK_SRC, TK_DATA, e.src, e.data);
    end else $display("token src=%0d data=%h", TK_SRC, TK_DATA);
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (TK_COUNT !== 32'(exp_count) || TK_VALID !== 1'b0) begin
      bad++;
      $display("FAIL single_count: got cnt=%0d vld=%b, required cnt=%0d vld=0", TK_COUNT, TK_VALID, exp_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    int n[N];
    int first, last;
    logic [N-1:0] acc;
    rst = 1'b1; wr_valid = '0; tk_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete(); exp_count = 0;
    for (int i = 0; i < N; i++) begin n[i] = 0; set_wr(i, mk(i, 0)); end
    wr_valid = 4'b1111;
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push(i, mk(i, r));
    first = -1; last = -1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      acc = wr_valid & WR_READY;
      if (TK_VALID && tk_ready) begin
        e = exp_q.pop_front(); exp_count++;
        if (first < 0) first = c;
        last = c;
        total++;
        if (TK_SRC !== e.src || TK_DATA !== e.data) begin
          bad++;
          $display("FAIL rr_token: got src=%0d data=%h, required src=%0d data=%h", TK_SRC, TK_DATA, e.src, e.data);
        end else $display("token src=%0d data=%h", TK_SRC, TK_DATA);
      end
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          n[i]++;
          if (n[i] >= 2) wr_valid[i] = 1'b0;
          else set_wr(i, mk(i, n[i]));
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rr_timeout: got %0d tokens outstanding, required 0", exp_q.size());
    end
    total++;
    if (first < 0 || last - first != 7) begin
      bad++;
      $display("FAIL rr_no_bubble: got span=%0d cycles for 8 tokens, required 7", last - first);
    end
    total++;
    if (TK_COUNT !== 32'(exp_count)) begin
      bad++;
      $display("FAIL rr_count: got %0d, required %0d", TK_COUNT, exp_count);
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] acc;
    tk_ready = 1'b0;
    set_wr(1, mk(1, 10)); set_wr(3, mk(3, 10)); wr_valid = 4'b1010;
    push(1, mk(1, 10)); push(3, mk(3, 10));
    @(negedge clk);
    total++;
    if (WR_READY !== 4'b0010) begin
      bad++;
      $display("FAIL bp_first_grant: got rdy=%b, required 0010", WR_READY);
    end
    @(posedge clk); #1 wr_valid = 4'b1000;
    repeat (5) begin
      @(negedge clk);
      total++;
      if (TK_VALID !== 1'b1 || TK_SRC !== 2'd1 || TK_DATA !== mk(1, 10) || WR_READY !== 4'b0000) begin
        bad++;
        $display("FAIL bp_hold: got vld=%b src=%0d data=%h rdy=%b, required vld=1 src=1 data=%h rdy=0000",
                 TK_VALID, TK_SRC, TK_DATA, WR_READY, mk(1, 10));
      end
      @(posedge clk); #1;
    end
    tk_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      acc = wr_valid & WR_READY;
      if (TK_VALID && tk_ready) begin
        e = exp_q.pop_front(); exp_count++;
        total++;
        if (TK_SRC !== e.src || TK_DATA !== e.data) begin
          bad++;
          $display("FAIL bp_token: got src=%0d data=%h, required src=%0d data=%h", TK_SRC, TK_DATA, e.src, e.data);
        end else $display("token src=%0d data=%h", TK_SRC, TK_DATA);
      end
      @(posedge clk); #1 wr_valid = wr_valid & ~acc;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL bp_timeout: got %0d tokens outstanding, required 0", exp_q.size());
    end
    repeat (2) begin
      @(negedge clk);
      total++;
      if (TK_VALID !== 1'b0) begin
        bad++;
        $display("FAIL bp_duplicate: got vld=%b src=%0d, required vld=0", TK_VALID, TK_SRC);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_pointer_skip();
    logic [N-1:0] wv_t[6]      = '{4'b0001, 4'b0001, 4'b0011, 4'b0001, 4'b0000, 4'b0000};
    logic [N-1:0] exp_rdy_t[6] = '{4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0000, 4'b0000};
    tk_ready = 1'b1;
    push(0, mk(0, 20)); push(0, mk(0, 21)); push(1, mk(1, 22)); push(0, mk(0, 23));
    for (int s = 0; s < 6; s++) begin
      case (s)
        0: set_wr(0, mk(0, 20));
        1: set_wr(0, mk(0, 21));
        2: begin set_wr(0, mk(0, 23)); set_wr(1, mk(1, 22)); end
        default: ;
      endcase
      wr_valid = wv_t[s];
      @(negedge clk);
      total++;
      if (WR_READY !== exp_rdy_t[s]) begin
        bad++;
        $display("FAIL ptr_grant step %0d: got rdy=%b, required %b", s, WR_READY, exp_rdy_t[s]);
      end
      if (TK_VALID && tk_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL ptr_extra: got src=%0d data=%h, required no token", TK_SRC, TK_DATA);
        end else begin
          e = exp_q.pop_front(); exp_count++;
          if (TK_SRC !== e.src || TK_DATA !== e.data) begin
            bad++;
            $display("FAIL ptr_token: got src=%0d data=%h, required src=%0d data=%h", TK_SRC, TK_DATA, e.src, e.data);
          end else $display("token src=%0d data=%h", TK_SRC, TK_DATA);
        end
      end
      @(posedge clk); #1;
    end
    total++;
    if (exp_q.size() != 0 || TK_VALID !== 1'b0) begin
      bad++;
      $display("FAIL ptr_drain: got outstanding=%0d vld=%b, required 0 and 0", exp_q.size(), TK_VALID);
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] acc;
    tk_ready = 1'b0;
    set_wr(2, mk(2, 40)); wr_valid = 4'b0100;
    @(negedge clk);
    @(posedge clk); #1 wr_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_wr(i, mk(i, 50));
    @(negedge clk);
    total++;
    if (TK_VALID !== 1'b1 || TK_SRC !== 2'd2) begin
      bad++;
      $display("FAIL mid_setup: got vld=%b src=%0d, required vld=1 src=2", TK_VALID, TK_SRC);
    end
    rst = 1'b1;
    #1;
    total++;
    if (TK_VALID !== 1'b0 || TK_COUNT !== 32'd0 || WR_READY !== 4'b0000 || TK_DATA !== '0) begin
      bad++;
      $display("FAIL mid_async_reset: got vld=%b cnt=%0d rdy=%b, required vld=0 cnt=0 rdy=0000",
               TK_VALID, TK_COUNT, WR_READY);
    end
    exp_q.delete(); exp_count = 0;
    @(posedge clk); #1 rst = 1'b0; tk_ready = 1'b1;
    for (int i = 0; i < N; i++) push(i, mk(i, 50));
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      acc = wr_valid & WR_READY;
      if (TK_VALID && tk_ready) begin
        e = exp_q.pop_front(); exp_count++;
        total++;
        if (TK_SRC !== e.src || TK_DATA !== e.data) begin
          bad++;
          $display("FAIL mid_token: got src=%0d data=%h, required src=%0d data=%h", TK_SRC, TK_DATA, e.src, e.data);
        end else $display("token src=%0d data=%h", TK_SRC, TK_DATA);
      end
      @(posedge clk); #1 wr_valid = wr_valid & ~acc;
    end
    total++;
    if (exp_q.size() != 0 || TK_COUNT !== 32'(exp_count)) begin
      bad++;
      $display("FAIL mid_resume: got outstanding=%0d cnt=%0d, required 0 and %0d", exp_q.size(), TK_COUNT, exp_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_pointer_skip();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_arbiter.md
Name: result_arbiter

Overview:
- Downstream of the worker array. Merges the worker-result streams of NUM_WORKERS workers into one token stream.
- That stream feeds the matching/token-routing stage.
- Arbitration is round-robin and fair. Each worker result is forwarded unmodified through a single registered output stage, tagged with the worker index that produced it.

Parameters:
- NUM_WORKERS, 4, number of worker result ports (2..16).
- WID_WIDTH, 2, width of the source-worker index; must be >= clog2(NUM_WORKERS).
- WORKER_RESULT_WIDTH, 67, width of one worker result: {dest_option[2:0], dest_addr[15:0], color[15:0], data[31:0]}.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- WR_VALID  in  NUM_WORKERS  per-worker result valid.
- WR_DATA  in  NUM_WORKERS*WORKER_RESULT_WIDTH  per-worker result; worker i occupies slice [i*WRW +: WRW].
- WR_READY  out  NUM_WORKERS  per-worker result accept.
- TK_VALID  out  1  merged token valid.
- TK_DATA  out  WORKER_RESULT_WIDTH  merged token, bit-identical to the accepted WR_DATA slice.
- TK_SRC  out  WID_WIDTH  index of the worker that produced TK_DATA.
- TK_READY  in  1  downstream accept.
- TK_COUNT  out  32  number of tokens delivered (TK_VALID && TK_READY); wraps modulo 2^32.

Behaviour:
- Reset (async, immediate):
  - TK_VALID=0, TK_DATA=0, TK_SRC=0, TK_COUNT=0, round-robin pointer ptr=0.
  - WR_READY=0 for all inputs while RST is high.
  - A token held in the output register at reset is discarded.
- Handshake: a transfer happens on a rising edge with VALID&&READY on the same channel. Valid/ready semantics match the worker's PC/WR ports.
- Senders must hold WR_VALID and WR_DATA stable until accepted. The block never drops or duplicates a result.
- can_load = !TK_VALID || TK_READY. The output register is free, or is being drained this cycle.
- Grant (combinational):
  - Search WR_VALID starting at index ptr, ascending, wrapping at NUM_WORKERS-1 to 0.
  - The first asserted index g is granted.
  - No valid input means no grant.
- WR_READY[i] = !RST && can_load && grant_valid && (i==g).
  - At most one WR_READY is high per cycle.
  - WR_READY may depend on TK_READY combinationally. Downstream must not derive TK_READY from WR_READY.
- On load (WR_VALID[g] && WR_READY[g]), at the next edge:
  - TK_DATA <= WR_DATA slice g.
  - TK_SRC <= g.
  - TK_VALID <= 1.
  - ptr <= (g+1) mod NUM_WORKERS.
- TK_VALID <= 0 at an edge where a TK handshake occurs and there is no load.
- Load and drain in the same cycle: the register is replaced with no bubble, giving 1 token/cycle sustained.
- Latency: 1 cycle from WR handshake to TK_VALID. Output is registered; TK_DATA is stable while TK_VALID && !TK_READY.
- Backpressure: while TK_VALID && !TK_READY, all WR_READY=0 and ptr holds.
- Fairness: an input that keeps WR_VALID asserted is granted within NUM_WORKERS loads.
- ptr advances only on a load. Idle cycles do not move it.
- TK_COUNT increments on each TK handshake.
- No internal FIFO. Storage is exactly one token.

Test Plan:
1. Reset check:
   - Stimulus: RST=1 with WR_VALID=4'b1111.
   - Response: WR_READY=0, TK_VALID=0, TK_COUNT=0.
   - Then release RST with TK_READY=1. Response: first grant is worker 0.
2. Single source:
   - Stimulus: worker 2 sends {3'b110, 16'h00ff, 16'heeee, 32'hdead_beef}; TK_READY=1.
   - Response: TK_VALID rises one cycle later, TK_DATA equals the input bit-exact, TK_SRC=2, TK_COUNT=1.
3. Round-robin:
   - Stimulus: all four workers hold distinct results continuously; TK_READY=1.
   - Response: TK_SRC sequence 0,1,2,3,0,1,2,3, one token per cycle, no bubbles.
4. Backpressure:
   - Stimulus: workers 1 and 3 valid; TK_READY=0 for 5 cycles.
   - Response: one token (src 1) is held with TK_DATA stable and all WR_READY=0.
   - Then raise TK_READY. Response: src 1 delivered, then src 3. Each worker's data appears exactly once.
5. Pointer skip:
   - Stimulus: ptr=1 after a worker-0 load; only worker 0 valid.
   - Response: worker 0 is granted again (wrap search) and ptr becomes 1.
6. Reset mid-operation:
   - Stimulus: assert RST while TK_VALID=1 and TK_READY=0.
   - Response: TK_VALID drops immediately (asynchronous), TK_COUNT=0.
   - After release: normal operation resumes from worker 0.
